// File: rtl/linebuffer_window9x9.sv
// Raster-stream to KxK window producer: K-1 line buffers feed a shift-register window,
// each complete window is emitted as one flat vector. Define LB_WIN_COORD_EN for top-left coordinate outputs.
module linebuffer_window9x9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 7,
  parameter int K     = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_i,
  input  logic                   pix_valid_i,
  input  logic                   pix_sof_i,
  output logic                   pix_ready_o,
  output logic [K*K*PIX_W-1:0]   win_o,
  output logic                   win_valid_o,
  input  logic                   win_ready_i
`ifdef LB_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row_o,
  output logic [$clog2(IMG_W)-1:0] win_col_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = K * K * PIX_W;
  localparam int RB = K * PIX_W;

  logic [CW-1:0]    col_r;
  logic [CW-1:0]    eff_col_s;
  logic [CW-1:0]    col_nxt_s;
  logic [RW-1:0]    row_r;
  logic [RW-1:0]    eff_row_s;
  logic [RW-1:0]    row_nxt_s;
  logic             accept_s;
  logic             emit_s;
  logic             last_col_s;
  logic [PIX_W-1:0] lb_r [K-1][IMG_W];
  logic [PIX_W-1:0] newcol_s [K];
  logic [WW-1:0]    win_sr_r;
  logic [WW-1:0]    win_nxt_s;

  // An undelivered window blocks new pixels so the window shift register cannot run ahead.
  assign pix_ready_o = !win_valid_o || win_ready_i;
  assign accept_s    = pix_valid_i && pix_ready_o;

  // Position of the offered pixel (a start-of-frame marker forces it to the origin) and its successor.
  always_comb begin
    eff_col_s  = pix_sof_i ? {CW{1'b0}} : col_r;
    eff_row_s  = pix_sof_i ? {RW{1'b0}} : row_r;
    last_col_s = (eff_col_s == CW'(IMG_W - 1));
    col_nxt_s  = last_col_s ? {CW{1'b0}} : eff_col_s + CW'(1);
    row_nxt_s  = last_col_s ? ((eff_row_s == RW'(IMG_H - 1)) ? {RW{1'b0}} : eff_row_s + RW'(1))
                            : eff_row_s;
    emit_s     = (eff_row_s >= RW'(K - 1)) && (eff_col_s >= CW'(K - 1));
  end

  // Raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  // Incoming column, top (oldest row) to bottom (new pixel); lb_r[j] holds row-1-j.
  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      newcol_s[j] = lb_r[K-2-j][eff_col_s];
    end
    newcol_s[K-1] = pix_i;
  end

  // Each window row drops its leftmost element and takes the new column entry on the right.
  always_comb begin
    win_nxt_s = {WW{1'b0}};
    for (int r = 0; r < K; r++) begin
      win_nxt_s[r*RB +: RB] = {newcol_s[r], win_sr_r[r*RB + PIX_W +: RB - PIX_W]};
    end
  end

  // Line-buffer storage and window shift register; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_r[0][eff_col_s] <= pix_i;
      for (int j = 1; j < K - 1; j++) begin
        lb_r[j][eff_col_s] <= lb_r[j-1][eff_col_s];
      end
      win_sr_r <= win_nxt_s;
    end
  end

  // Output window register with valid/ready hold; a fresh window replaces one being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_o <= 1'b0;
      win_o       <= {WW{1'b0}};
`ifdef LB_WIN_COORD_EN
      win_row_o   <= {RW{1'b0}};
      win_col_o   <= {CW{1'b0}};
`endif
    end else if (accept_s && emit_s) begin
      win_valid_o <= 1'b1;
      win_o       <= win_nxt_s;
`ifdef LB_WIN_COORD_EN
      win_row_o   <= eff_row_s - RW'(K - 1);
      win_col_o   <= eff_col_s - CW'(K - 1);
`endif
    end else if (win_ready_i) begin
      win_valid_o <= 1'b0;
    end
  end

endmodule
